// File: rtl/sequence_round_ctrl.sv
// Round controller for the sequence-entry puzzle: draws a 4-digit target from an LFSR,
// shows it, times user entry, and tracks strikes until PASS or FAIL.
module sequence_round_ctrl #(
  parameter int unsigned SHOW_SEC    = 3,
  parameter int unsigned INPUT_SEC   = 15,
  parameter int unsigned MAX_STRIKES = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        one_sec,
  input  logic        button_next,
  input  logic [3:0]  digit_code,
  output logic [15:0] sequence_code,
  output logic [7:0]  game_state,
  output logic [1:0]  strikes,
  output logic [7:0]  time_left,
  output logic        round_pass,
  output logic        round_fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_INPUT, S_CHECK, S_STRIKE, S_PASS, S_FAIL
  } state_t;

  localparam logic [7:0] SHOW_TIME  = 8'(SHOW_SEC);
  localparam logic [7:0] INPUT_TIME = 8'(INPUT_SEC);
  localparam logic [1:0] STRIKE_MAX = 2'(MAX_STRIKES);

  state_t      state, state_n;
  logic [15:0] lfsr;
  logic [15:0] seq_n;
  logic [1:0]  strikes_n, new_strikes;
  logic [7:0]  time_n;
  logic [1:0]  digit_idx, idx_n;
  logic        mismatch, mismatch_n;
  logic        pass_n, fail_n;
  logic [3:0]  expected_digit;
  logic        expire;

  // Active-low one-hot display code for a 2-bit digit value.
  function automatic logic [3:0] digit_map(input logic [1:0] p);
    return ~(4'b0001 << p);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      lfsr          <= LFSR_SEED;
      sequence_code <= 16'hFFFF;
      strikes       <= 2'd0;
      time_left     <= 8'd0;
      digit_idx     <= 2'd0;
      mismatch      <= 1'b0;
      round_pass    <= 1'b0;
      round_fail    <= 1'b0;
    end else begin
      state         <= state_n;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sequence_code <= seq_n;
      strikes       <= strikes_n;
      time_left     <= time_n;
      digit_idx     <= idx_n;
      mismatch      <= mismatch_n;
      round_pass    <= pass_n;
      round_fail    <= fail_n;
    end
  end

  always_comb begin
    expected_digit = sequence_code[15:12];
    case (digit_idx)
      2'd1:    expected_digit = sequence_code[11:8];
      2'd2:    expected_digit = sequence_code[7:4];
      2'd3:    expected_digit = sequence_code[3:0];
      default: expected_digit = sequence_code[15:12];
    endcase
  end

  // A second tick that empties the clock wins over a same-cycle button press.
  assign expire      = one_sec && (time_left <= 8'd1);
  assign new_strikes = strikes + 2'd1;

  always_comb begin
    state_n    = state;
    seq_n      = sequence_code;
    strikes_n  = strikes;
    time_n     = time_left;
    idx_n      = digit_idx;
    mismatch_n = mismatch;
    pass_n     = 1'b0;
    fail_n     = 1'b0;
    case (state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          seq_n     = {digit_map(lfsr[7:6]), digit_map(lfsr[5:4]),
                       digit_map(lfsr[3:2]), digit_map(lfsr[1:0])};
          strikes_n = 2'd0;
          time_n    = SHOW_TIME;
          state_n   = S_SHOW;
        end
      end
      S_SHOW: begin
        if (time_left == 8'd0) begin
          state_n    = S_INPUT;
          time_n     = INPUT_TIME;
          idx_n      = 2'd0;
          mismatch_n = 1'b0;
        end else if (one_sec) begin
          time_n = time_left - 8'd1;
        end
      end
      S_INPUT: begin
        if (expire) begin
          time_n     = 8'd0;
          mismatch_n = 1'b1;
          state_n    = S_CHECK;
        end else begin
          if (one_sec)
            time_n = time_left - 8'd1;
          if (button_next) begin
            if (digit_code != expected_digit)
              mismatch_n = 1'b1;
            if (digit_idx == 2'd3)
              state_n = S_CHECK;
            else
              idx_n = digit_idx + 2'd1;
          end
        end
      end
      S_CHECK: begin
        if (!mismatch) begin
          state_n = S_PASS;
          pass_n  = 1'b1;
        end else begin
          strikes_n = new_strikes;
          if (new_strikes == STRIKE_MAX) begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
          end else begin
            state_n = S_STRIKE;
          end
        end
      end
      S_STRIKE: begin
        time_n  = SHOW_TIME;
        state_n = S_SHOW;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // CHECK keeps the INPUT code so the display does not flicker for one cycle.
  always_comb begin
    game_state = 8'h00;
    case (state)
      S_SHOW:           game_state = 8'h10;
      S_INPUT, S_CHECK: game_state = 8'h11;
      S_STRIKE:         game_state = 8'h30;
      S_PASS:           game_state = 8'h20;
      S_FAIL:           game_state = 8'hF0;
      default:          game_state = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sequence_round_ctrl.sv
// Scoreboard bench for sequence_round_ctrl: stimulus queues the expected output snapshot,
// a negedge monitor compares whenever the visible outputs change.
module tb_sequence_round_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, start, one_sec, button_next;
  logic [3:0]  digit_code;
  logic [15:0] sequence_code;
  logic [7:0]  game_state, time_left;
  logic [1:0]  strikes;
  logic        round_pass, round_fail;

  sequence_round_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .one_sec(one_sec),
    .button_next(button_next), .digit_code(digit_code),
    .sequence_code(sequence_code), .game_state(game_state), .strikes(strikes),
    .time_left(time_left), .round_pass(round_pass), .round_fail(round_fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  gs;
    logic [1:0]  str;
    logic [15:0] seq;
    logic [7:0]  tl;
    logic        p;
    logic        f;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_seq;
  logic [1:0]  m_str;

  // Reference LFSR, used to predict the code drawn on each start.
  always @(posedge clk) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [3:0] dmap(input logic [1:0] p);
    case (p)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [15:0] code_from(input logic [15:0] l);
    return {dmap(l[7:6]), dmap(l[5:4]), dmap(l[3:2]), dmap(l[1:0])};
  endfunction

  function automatic logic [3:0] digit_of(input int k);
    logic [15:0] tmp;
    tmp = m_seq >> (4 * (3 - k));
    return tmp[3:0];
  endfunction

  task automatic pushExp(input string tag, input logic [7:0] gs, input logic [1:0] str,
                         input logic [15:0] seq, input logic [7:0] tl,
                         input logic p, input logic f);
    snap_t s;
    s = '{gs, str, seq, tl, p, f};
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input snap_t want, input snap_t got);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got gs=%h str=%0d seq=%h tl=%0d pass=%b fail=%b, want gs=%h str=%0d seq=%h tl=%0d pass=%b fail=%b",
               tag, got.gs, got.str, got.seq, got.tl, got.p, got.f,
               want.gs, want.str, want.seq, want.tl, want.p, want.f);
    end
  endtask

  // Monitor: a change in the visible outputs consumes one scoreboard entry;
  // quiet cycles must show no pass/fail pulse.
  snap_t prev_s = 'x;
  always @(negedge clk) begin
    snap_t cur, want;
    string tag;
    cur = '{game_state, strikes, sequence_code, time_left, round_pass, round_fail};
    if (cur[35:2] !== prev_s[35:2]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_change: got gs=%h str=%0d seq=%h tl=%0d, want no change",
                 cur.gs, cur.str, cur.seq, cur.tl);
      end else begin
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        checkOutput(tag, want, cur);
      end
    end else begin
      n_cmp++;
      if (cur.p !== 1'b0 || cur.f !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stray_pulse: got pass=%b fail=%b, want 0 0", cur.p, cur.f);
      end
    end
    prev_s = cur;
  end

  // Drives one cycle of inputs; always entered and left at a negedge.
  task automatic applyStimulus(input logic st, input logic os, input logic bn, input logic [3:0] dc);
    start = st; one_sec = os; button_next = bn; digit_code = dc;
    @(negedge clk);
    start = 1'b0; one_sec = 1'b0; button_next = 1'b0;
  endtask

  task automatic startRound(input logic [15:0] seq);
    m_seq = seq;
    m_str = 2'd0;
    pushExp("start", 8'h10, 2'd0, seq, 8'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
  endtask

  task automatic showPhase(input logic noise);
    for (int t = 3; t >= 1; t--) begin
      if (noise) applyStimulus(1'b0, 1'b0, 1'b1, digit_of(0));
      pushExp("show_tick", 8'h10, m_str, m_seq, 8'(t - 1), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
    end
    pushExp("to_input", 8'h11, m_str, m_seq, 8'd15, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic enterDigit(input int k, input logic wrong);
    applyStimulus(1'b0, 1'b0, 1'b1, wrong ? (digit_of(k) ^ 4'b0011) : digit_of(k));
  endtask

  task automatic tickDown(input int from_tl, input int to_tl);
    for (int t = from_tl - 1; t >= to_tl; t--) begin
      pushExp("input_tick", 8'h11, m_str, m_seq, 8'(t), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
    end
  endtask

  // Final expiring tick (optionally with a coincident button) and the strike or fail that follows.
  task automatic expireInput(input logic with_button);
    pushExp("timeout", 8'h11, m_str, m_seq, 8'd0, 1'b0, 1'b0);
    m_str = m_str + 2'd1;
    if (m_str == 2'd3) begin
      pushExp("fail", 8'hF0, m_str, m_seq, 8'd0, 1'b0, 1'b1);
    end else begin
      pushExp("strike", 8'h30, m_str, m_seq, 8'd0, 1'b0, 1'b0);
      pushExp("reshow", 8'h10, m_str, m_seq, 8'd3, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, with_button, digit_of(3));
    @(negedge clk);
    if (m_str != 2'd3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; one_sec = 1'b0; button_next = 1'b0; digit_code = 4'hF;
    pushExp("reset", 8'h00, 2'd0, 16'hFFFF, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Round A: first start sees the seed, whose low byte E1 maps to 7BED.
    startRound(16'h7BED);
    showPhase(1'b1);
    for (int k = 0; k < 3; k++) enterDigit(k, 1'b0);
    pushExp("pass_a", 8'h20, 2'd0, m_seq, 8'd15, 1'b1, 1'b0);
    enterDigit(3, 1'b0);
    repeat (2) @(negedge clk);

    // Round B: wrong second digit, then a correct retry.
    startRound(code_from(m_lfsr));
    showPhase(1'b0);
    enterDigit(0, 1'b0);
    enterDigit(1, 1'b1);
    enterDigit(2, 1'b0);
    m_str = 2'd1;
    pushExp("strike_b", 8'h30, 2'd1, m_seq, 8'd15, 1'b0, 1'b0);
    pushExp("reshow_b", 8'h10, 2'd1, m_seq, 8'd3, 1'b0, 1'b0);
    enterDigit(3, 1'b0);
    repeat (2) @(negedge clk);
    showPhase(1'b0);
    for (int k = 0; k < 3; k++) enterDigit(k, 1'b0);
    pushExp("pass_b", 8'h20, 2'd1, m_seq, 8'd15, 1'b1, 1'b0);
    enterDigit(3, 1'b0);
    repeat (2) @(negedge clk);

    // Round C: three timeouts after two submissions each end in FAIL.
    startRound(code_from(m_lfsr));
    for (int r = 0; r < 3; r++) begin
      showPhase(1'b0);
      enterDigit(0, 1'b0);
      enterDigit(1, 1'b0);
      tickDown(15, 1);
      expireInput(1'b0);
    end
    repeat (2) @(negedge clk);

    // Round D: button coincides with the expiring tick after three correct digits.
    startRound(code_from(m_lfsr));
    showPhase(1'b0);
    for (int k = 0; k < 3; k++) enterDigit(k, 1'b0);
    tickDown(15, 1);
    expireInput(1'b1);

    // Reset while two digits have been entered, then idle-time noise.
    showPhase(1'b0);
    enterDigit(0, 1'b0);
    enterDigit(1, 1'b0);
    pushExp("reset_mid", 8'h00, 2'd0, 16'hFFFF, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_str = 2'd0;
    m_seq = 16'hFFFF;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hE);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hE);
    startRound(code_from(m_lfsr));
    showPhase(1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL pending_expected: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
